// File: rtl/simd_sequencer.sv
// simd_sequencer
//   Program sequencer for the SIMD datapath. Fetches instructions from the
//   instruction BRAM starting at a host-supplied base address. It presents one
//   instruction every two clk cycles together with a pipeline-advance strobe.
//   After a HALT it flushes the datapath pipeline with bubble advances, then
//   pulses done.
//
// Ports
//   clk          clock
//   rstn         synchronous active-low reset
//   start        host start pulse, sampled only while idle
//   base_pc      first instruction address, captured with start
//   stall        freezes the issue phase; no advance while high
//   imem_en      instruction BRAM read enable
//   imem_addr    instruction BRAM address
//   imem_rdata   BRAM read data, valid one cycle after imem_en
//   instr_out    instruction to the decoder, zero unless instr_valid
//   instr_valid  instr_out carries a real instruction on this advance
//   adv          pipeline-advance strobe
//   busy         program running or pipeline draining
//   done         one-cycle completion pulse
//   overrun      sticky: pc reached its maximum without a HALT
//   issue_count  instructions issued since the last start (saturating)
module simd_sequencer #(
    parameter int unsigned ADDR_WIDTH                = 10,
    parameter int unsigned INSTR_WIDTH               = 35,
    parameter int unsigned OPCODE_WIDTH              = 4,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE   = 4'hF,
    parameter int unsigned PIPE_DEPTH                = 3
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_pc,
    input  logic                   stall,
    output logic                   imem_en,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    output logic                   adv,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun,
    output logic [15:0]            issue_count
);

    localparam int unsigned CNT_WIDTH = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BUBBLE = CNT_WIDTH'(PIPE_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                  state, state_next;
    logic                    phase, phase_next;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [CNT_WIDTH-1:0]    bub_cnt;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    accept;
    logic                    issue;
    logic                    bubble;

    assign opcode = imem_rdata[INSTR_WIDTH-1 -: OPCODE_WIDTH];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            phase <= 1'b0;
        end else begin
            state <= state_next;
            phase <= phase_next;
        end
    end

    always_comb begin
        state_next  = state;
        phase_next  = 1'b0;
        imem_en     = 1'b0;
        imem_addr   = '0;
        instr_out   = '0;
        instr_valid = 1'b0;
        adv         = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        issue       = 1'b0;
        bubble      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // Enable and address stay up in phase 1 so the BRAM keeps
                // re-reading the same word while stalled.
                imem_en   = 1'b1;
                imem_addr = pc;
                if (!phase) begin
                    phase_next = 1'b1;
                end else if (opcode == HALT_OPCODE) begin
                    state_next = DRAIN;
                end else if (stall) begin
                    phase_next = 1'b1;
                end else begin
                    adv         = 1'b1;
                    instr_valid = 1'b1;
                    instr_out   = imem_rdata;
                    issue       = 1'b1;
                    if (pc == '1) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!phase) begin
                    phase_next = 1'b1;
                end else if (stall) begin
                    phase_next = 1'b1;
                end else begin
                    adv    = 1'b1;
                    bubble = 1'b1;
                    if (bub_cnt == LAST_BUBBLE) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc          <= '0;
            issue_count <= '0;
            overrun     <= 1'b0;
            bub_cnt     <= '0;
        end else begin
            if (accept) begin
                pc          <= base_pc;
                issue_count <= '0;
                overrun     <= 1'b0;
                bub_cnt     <= '0;
            end
            if (issue) begin
                if (issue_count != 16'hFFFF) begin
                    issue_count <= issue_count + 16'd1;
                end
                // pc never wraps: the last address ends the program instead.
                if (pc == '1) begin
                    overrun <= 1'b1;
                end else begin
                    pc <= pc + ADDR_WIDTH'(1);
                end
            end
            if (bubble) begin
                bub_cnt <= bub_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
